// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing, derived totals and shared types
// for the scan controller and its sync delay line.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF =
        H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF =
        V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync fields mean "pulse asserted", independent of pin polarity.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
    } vga_ctrl_t;

    function automatic logic [11:0] rgb332_to_444(input logic [7:0] c);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[7:5];
        g = c[4:2];
        b = c[1:0];
        return {r, r[2], g, g[2], b, b};
    endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// Fixed-depth shift register for sync/visible flags, used to line
// the control signals up with the registered colour path.
module vga_sync_pipe
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  vga_ctrl_t din,
    output vga_ctrl_t dout
);

    vga_ctrl_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// Raster counters, sync decode and latency-matched RGB332 to
// 4-bit-per-channel DAC output for a VGA connector.
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = H_ACTIVE_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_ACTIVE    = V_ACTIVE_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   RGB_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int D       = RGB_LATENCY + 1;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [7:0]  rgb_q;
    logic [11:0] rgb444;
    vga_ctrl_t   ctrl_raw;
    vga_ctrl_t   ctrl_dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign pixelX       = h_cnt;
    assign pixelY       = v_cnt;
    // Strobe at the top of vertical blanking, aligned to the counters.
    assign startOfFrame = (h_cnt == 11'd0) && (v_cnt == V_VIS);

    assign ctrl_raw.hsync   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign ctrl_raw.vsync   = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign ctrl_raw.visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    vga_sync_pipe #(
        .DEPTH (D)
    ) u_sync_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (ctrl_raw),
        .dout  (ctrl_dly)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= RGB_in;
        end
    end

    assign rgb444 = rgb332_to_444(rgb_q);

    assign vga_r  = ctrl_dly.visible ? rgb444[11:8] : 4'd0;
    assign vga_g  = ctrl_dly.visible ? rgb444[7:4]  : 4'd0;
    assign vga_b  = ctrl_dly.visible ? rgb444[3:0]  : 4'd0;
    assign hsync  = ctrl_dly.hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync  = ctrl_dly.vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign blankN = ctrl_dly.visible;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller on a shrunken raster so several
// frames fit in a short run; outputs are predicted from position.
module tb_vga_scan_controller;

    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VA = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LAT = 1;
    localparam int D = LAT + 1;
    localparam logic SA = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  RGB_in;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        blankN;

    int errors = 0;
    int checks = 0;
    logic [7:0] hist [0:4095];
    int sof_first;
    int sof_last;
    int sof_count;

    vga_scan_controller #(
        .H_ACTIVE    (HA),
        .H_FP        (HF),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_ACTIVE    (VA),
        .V_FP        (VF),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .SYNC_ACTIVE (SA),
        .RGB_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RGB_in       (RGB_in),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .hsync        (hsync),
        .vsync        (vsync),
        .blankN       (blankN)
    );

    always #5 clk = ~clk;

    function automatic int px(int p);
        return p % HT;
    endfunction

    function automatic int py(int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit vis(int p);
        if (p < 0) return 1'b0;
        return px(p) < HA && py(p) < VA;
    endfunction

    function automatic bit hs_on(int p);
        if (p < 0) return 1'b0;
        return px(p) >= HA + HF && px(p) < HA + HF + HS;
    endfunction

    function automatic bit vs_on(int p);
        if (p < 0) return 1'b0;
        return py(p) >= VA + VF && py(p) < VA + VF + VS;
    endfunction

    // 3-bit to 4-bit by bit replication, 2-bit to 4-bit by x5.
    function automatic logic [11:0] expand(logic [7:0] c);
        int r, g, b;
        r = c / 32;
        g = (c / 4) % 8;
        b = c % 4;
        return 12'(((r * 2 + r / 4) * 256) + ((g * 2 + g / 4) * 16) + b * 5);
    endfunction

    function automatic logic [11:0] lit(logic [7:0] c);
        case (c)
            8'hE0:   return 12'hF00;
            8'h1C:   return 12'h0F0;
            8'h03:   return 12'h00F;
            default: return 12'h99A;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output at model cycle n (n = cycles since release).
    task automatic check_cycle(int n, bit directed);
        logic [11:0] col;
        int p;
        p = n - D;
        check("pixelX", 32'(pixelX), 32'(px(n)));
        check("pixelY", 32'(pixelY), 32'(py(n)));
        check("sof", 32'(startOfFrame),
              32'(px(n) == 0 && py(n) == VA));
        check("hsync", 32'(hsync), 32'(hs_on(p) ? SA : !SA));
        check("vsync", 32'(vsync), 32'(vs_on(p) ? SA : !SA));
        check("blankN", 32'(blankN), 32'(vis(p)));
        col = vis(p) ? expand(hist[n-1]) : 12'h000;
        check("colour", 32'({vga_r, vga_g, vga_b}), 32'(col));
        if (directed && vis(p)) begin
            check("colour_lit", 32'({vga_r, vga_g, vga_b}),
                  32'(lit(hist[n-1])));
        end
        if (startOfFrame) begin
            if (sof_count == 0) sof_first = n;
            sof_last = n;
            sof_count++;
        end
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_x"}, 32'(pixelX), 32'd0);
        check({tag, "_y"}, 32'(pixelY), 32'd0);
        check({tag, "_sof"}, 32'(startOfFrame), 32'd0);
        check({tag, "_hs"}, 32'(hsync), 32'(!SA));
        check({tag, "_vs"}, 32'(vsync), 32'(!SA));
        check({tag, "_bn"}, 32'(blankN), 32'd0);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    endtask

    initial begin
        logic [7:0] tbl [4];
        int n;
        int k;
        bit directed;
        tbl[0] = 8'hE0;
        tbl[1] = 8'h1C;
        tbl[2] = 8'h03;
        tbl[3] = 8'h92;
        sof_count = 0;
        sof_first = 0;
        sof_last = 0;
        reset = 1'b1;
        RGB_in = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_state("rst");

        // Release: this negedge is in cycle 0 (counters still 0).
        reset = 1'b0;
        n = 0;
        while (n < 1000) begin
            directed = (n >= 600 + D) && (n < 800);
            check_cycle(n, directed);
            if (n < 600) RGB_in = 8'($urandom);
            else if (n < 800) RGB_in = tbl[n % 4];
            else RGB_in = 8'hFF;
            hist[n] = RGB_in;
            @(negedge clk);
            n++;
        end
        check("sof_count", 32'(sof_count), 32'd2);
        check("sof_period", 32'(sof_last - sof_first), 32'(HT * VT));

        // Walk to a point inside both hsync and vsync, then reset.
        k = 0;
        while (!(px(n) == HA + HF + 3 && py(n) == VA + VF + 1)
               && k < 2 * HT * VT) begin
            check_cycle(n, 1'b0);
            RGB_in = 8'($urandom);
            hist[n] = RGB_in;
            @(negedge clk);
            n++;
            k++;
        end
        check("reach_sync", 32'(k < 2 * HT * VT), 32'd1);
        check_cycle(n, 1'b0);
        reset = 1'b1;
        RGB_in = 8'hFF;
        @(negedge clk);
        check_reset_state("mid");
        reset = 1'b0;

        sof_count = 0;
        for (int m = 0; m < HT * VT + 20; m++) begin
            check_cycle(m, 1'b0);
            RGB_in = 8'($urandom);
            hist[m] = RGB_in;
            @(negedge clk);
        end
        check("sof_after_rst", 32'(sof_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
